ov7670_rgb565_bin2x2: RTL and testbench

- Downstream stage of the OV7670 capture block. Consumes its AXI4-Stream RGB565 pixels (tuser marks start of frame, tlast marks end of line).
- Emits a half-resolution stream (WIDTH/2 x HEIGHT/2), where each output pixel is the rounded average of a 2x2 input block.
- Uses one line buffer of horizontal pair sums. Sits between capture and the VDMA/downstream AXIS consumer, in the pclk domain.

---
 rtl/ov7670_pkg.sv | 30 +++
 rtl/ov7670_line_ram.sv | 38 +++
 rtl/ov7670_rgb565_bin2x2.sv | 156 +++++++++++++++
 tb/tb_ov7670_rgb565_bin2x2.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared RGB565 field positions and 2x2 binning widths
//
// Purpose: constants and types shared by the OV7670 binning datapath.
//   RGB565 bit positions, horizontal pair-sum widths, line-buffer word
//   layout and the rounding constant used when dividing a 2x2 sum by 4.
package ov7670_pkg;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  // Sum of two 5/6-bit channels needs one extra bit.
  localparam int R_SUM_W = 6;
  localparam int G_SUM_W = 7;
  localparam int B_SUM_W = 6;
  localparam int LB_W    = R_SUM_W + G_SUM_W + B_SUM_W;

  // Added before >>2 so the 2x2 average rounds half-up.
  localparam int ROUND = 2;

  typedef struct packed {
    logic [R_SUM_W-1:0] r;
    logic [G_SUM_W-1:0] g;
    logic [B_SUM_W-1:0] b;
  } pair_sum_t;

endpackage

// File: rtl/ov7670_line_ram.sv
// rtl/ov7670_line_ram.sv - simple dual-port line buffer of horizontal pair sums
//
// Purpose: one synchronous write port, one synchronous read port with
//   1-cycle latency; rd_data holds until the next read. No reset.
// Ports:
//   clk      - clock
//   we       - write enable
//   wr_addr  - write address
//   wr_data  - write data
//   re       - read enable
//   rd_addr  - read address
//   rd_data  - registered read data
module ov7670_line_ram #(
  parameter int DEPTH  = 320,
  parameter int DATA_W = 19,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    if (re) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ov7670_rgb565_bin2x2.sv
// rtl/ov7670_rgb565_bin2x2.sv - 2x2 averaging downscaler for an RGB565 AXI4-Stream
//
// Purpose: consumes WIDTH x HEIGHT RGB565 frames and emits WIDTH/2 x HEIGHT/2
//   frames, each output pixel the rounded mean of a 2x2 input block.
// Ports:
//   pclk, capture_rst_n            - clock, async active-low reset
//   s_tdata/tvalid/tready/tuser/tlast - input stream (tuser = SOF, tlast = EOL)
//   m_tdata/tvalid/tready/tuser/tlast - output stream
//   line_err                       - pulse: tlast missing or misplaced
//   frame_done                     - pulse: tlast accepted on the last row
module ov7670_rgb565_bin2x2
  import ov7670_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        pclk,
  input  logic        capture_rst_n,
  input  logic [15:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tuser,
  input  logic        s_tlast,
  output logic [15:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tuser,
  output logic        m_tlast,
  output logic        line_err,
  output logic        frame_done
);

  localparam int ADDR_W = $clog2(WIDTH / 2);
  localparam int COL_W  = ADDR_W + 1;
  localparam int ROW_W  = $clog2(HEIGHT);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              sof_pend;
  logic [4:0]        r0;
  logic [5:0]        g0;
  logic [4:0]        b0;

  logic              accept;
  logic [COL_W-1:0]  cur_col;
  logic [ROW_W-1:0]  cur_row;
  logic [ROW_W-1:0]  next_row;
  logic              odd_col;
  logic              odd_row;
  logic              at_last_col;
  logic              end_line;
  logic              load;
  logic              lb_we;
  logic              lb_re;
  logic [ADDR_W-1:0] lb_addr;
  pair_sum_t         pair_sum;
  pair_sum_t         lb_rd;
  logic [R_SUM_W:0]  tot_r;
  logic [G_SUM_W:0]  tot_g;
  logic [B_SUM_W:0]  tot_b;

  assign s_tready = !m_tvalid || m_tready;
  assign accept   = s_tvalid && s_tready;

  // A start-of-frame beat is always positioned at the origin, so a restart
  // mid-frame lands on an even column and overwrites any held half-pair.
  assign cur_col     = s_tuser ? '0 : col;
  assign cur_row     = s_tuser ? '0 : row;
  assign next_row    = (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
  assign odd_col     = cur_col[0];
  assign odd_row     = cur_row[0];
  assign at_last_col = (cur_col == LAST_COL);
  assign end_line    = s_tlast || at_last_col;

  assign pair_sum.r = R_SUM_W'(r0) + R_SUM_W'(s_tdata[R_MSB:R_LSB]);
  assign pair_sum.g = G_SUM_W'(g0) + G_SUM_W'(s_tdata[G_MSB:G_LSB]);
  assign pair_sum.b = B_SUM_W'(b0) + B_SUM_W'(s_tdata[B_MSB:B_LSB]);

  // Reads are only issued on even columns, so the RAM output still holds the
  // upper-row pair when the matching odd column arrives, however late.
  assign lb_addr = cur_col[COL_W-1:1];
  assign lb_re   = accept && !odd_col;
  assign lb_we   = accept && odd_col && !odd_row;
  assign load    = accept && odd_col && odd_row;

  assign tot_r = {1'b0, pair_sum.r} + {1'b0, lb_rd.r} + (R_SUM_W + 1)'(ROUND);
  assign tot_g = {1'b0, pair_sum.g} + {1'b0, lb_rd.g} + (G_SUM_W + 1)'(ROUND);
  assign tot_b = {1'b0, pair_sum.b} + {1'b0, lb_rd.b} + (B_SUM_W + 1)'(ROUND);

  ov7670_line_ram #(
    .DEPTH  (WIDTH / 2),
    .DATA_W (LB_W),
    .ADDR_W (ADDR_W)
  ) u_line_ram (
    .clk     (pclk),
    .we      (lb_we),
    .wr_addr (lb_addr),
    .wr_data (pair_sum),
    .re      (lb_re),
    .rd_addr (lb_addr),
    .rd_data (lb_rd)
  );

  always_ff @(posedge pclk or negedge capture_rst_n) begin
    if (!capture_rst_n) begin
      col        <= '0;
      row        <= '0;
      sof_pend   <= 1'b0;
      r0         <= '0;
      g0         <= '0;
      b0         <= '0;
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      m_tuser    <= 1'b0;
      m_tlast    <= 1'b0;
      line_err   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      line_err   <= 1'b0;
      frame_done <= 1'b0;
      if (m_tready) begin
        m_tvalid <= 1'b0;
      end
      if (accept) begin
        if (!odd_col) begin
          r0 <= s_tdata[R_MSB:R_LSB];
          g0 <= s_tdata[G_MSB:G_LSB];
          b0 <= s_tdata[B_MSB:B_LSB];
        end
        // A missing tlast at the last column is treated as an implicit end of line.
        if (end_line) begin
          col <= '0;
          row <= next_row;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
        line_err   <= (s_tlast != at_last_col);
        frame_done <= s_tlast && (cur_row == LAST_ROW);
        if (s_tuser) begin
          sof_pend <= 1'b1;
        end
        if (load) begin
          m_tvalid <= 1'b1;
          m_tdata  <= {tot_r[R_SUM_W:2], tot_g[G_SUM_W:2], tot_b[B_SUM_W:2]};
          m_tuser  <= sof_pend;
          m_tlast  <= at_last_col;
          sof_pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_rgb565_bin2x2.sv
// tb/tb_ov7670_rgb565_bin2x2.sv - self-checking bench for the 2x2 RGB565 binner
module tb_ov7670_rgb565_bin2x2;

  localparam int W = 8;
  localparam int H = 4;

  logic        pclk;
  logic        capture_rst_n;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tuser;
  logic        s_tlast;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tuser;
  logic        m_tlast;
  logic        line_err;
  logic        frame_done;

  ov7670_rgb565_bin2x2 #(.WIDTH(W), .HEIGHT(H)) dut (
    .pclk          (pclk),
    .capture_rst_n (capture_rst_n),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .s_tuser       (s_tuser),
    .s_tlast       (s_tlast),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tuser       (m_tuser),
    .m_tlast       (m_tlast),
    .line_err      (line_err),
    .frame_done    (frame_done)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Block pattern {p11, p10, p01, p00}: p00/p01 top row, p10/p11 bottom row.
  typedef struct {
    logic [3:0][15:0] p;
    logic [15:0]      expd;
    string            name;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic        u;
    logic        l;
  } exp_t;

  vec_t        tbl [6];
  exp_t        q [$];
  int          total;
  int          bad;
  int          out_cnt;
  int          le_cnt;
  int          fd_cnt;
  int          rdy_mode;
  logic [3:0][15:0] pat;
  logic [15:0] exp_px;
  logic        exp_sof;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge pclk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'b0;
        default: m_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge pclk);
      if (capture_rst_n) begin
        if (line_err) le_cnt++;
        if (frame_done) fd_cnt++;
        if (m_tvalid && m_tready) begin
          out_cnt++;
          if (q.size() == 0) begin
            check("unexpected_output", {15'd0, m_tdata, m_tuser}, 32'hdead);
          end else begin
            e = q.pop_front();
            check("out_pixel", {13'd0, m_tdata, m_tuser, m_tlast}, {13'd0, e});
          end
        end
      end
    end
  endtask

  task automatic send_beat(input logic [15:0] d, input logic u, input logic l);
    int n;
    n = 0;
    s_tdata  = d;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge pclk);
    while (!s_tready && n < 200) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 200) check("s_tready_timeout", 32'd0, 32'd1);
    @(posedge pclk);
    #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_line(input int r, input int c0, input int c1, input logic user, input logic eol);
    logic u;
    logic l;
    for (int c = c0; c <= c1; c++) begin
      u = user && (c == c0);
      l = eol && (c == c1);
      if (u) exp_sof = 1'b1;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        q.push_back('{d: exp_px, u: exp_sof, l: (c == W - 1)});
        exp_sof = 1'b0;
      end
      send_beat(pat[(r % 2) * 2 + (c % 2)], u, l);
    end
  endtask

  task automatic send_frame();
    for (int r = 0; r < H; r++) send_line(r, 0, W - 1, (r == 0), 1'b1);
  endtask

  task automatic use_vec(input int i);
    pat    = tbl[i].p;
    exp_px = tbl[i].expd;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 300) check("drain_timeout", q.size(), 32'd0);
    repeat (3) @(negedge pclk);
  endtask

  int o0, l0, f0;
  task automatic snap();
    o0 = out_cnt;
    l0 = le_cnt;
    f0 = fd_cnt;
  endtask

  task automatic check_counts(input string name, input int outs, input int les, input int fds);
    check({name, "_outputs"}, out_cnt - o0, outs);
    check({name, "_line_err"}, le_cnt - l0, les);
    check({name, "_frame_done"}, fd_cnt - f0, fds);
  endtask

  initial begin
    tbl[0] = '{p: {16'hF800, 16'hF800, 16'hF800, 16'hF800}, expd: 16'hF800, name: "uniform_red"};
    tbl[1] = '{p: {16'h27E1, 16'h1FE0, 16'h17E0, 16'h0800}, expd: 16'h1DE0, name: "mixed_block"};
    tbl[2] = '{p: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, expd: 16'hFFFF, name: "all_ones"};
    tbl[3] = '{p: {16'h0000, 16'h0000, 16'h0000, 16'h0000}, expd: 16'h0000, name: "all_zero"};
    tbl[4] = '{p: {16'h1000, 16'h0020, 16'h0001, 16'h0001}, expd: 16'h0801, name: "round_up"};
    tbl[5] = '{p: {16'h001E, 16'h001F, 16'h003F, 16'h083F}, expd: 16'h003F, name: "round_edge"};

    total = 0; bad = 0; out_cnt = 0; le_cnt = 0; fd_cnt = 0;
    rdy_mode = 0; exp_sof = 1'b0;
    capture_rst_n = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1;
    pat = '0; exp_px = '0;
    fork
      ready_drv();
      monitor();
    join_none

    repeat (3) @(posedge pclk);
    #1;
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tdata", m_tdata, 16'h0);
    check("rst_m_tuser_tlast", {m_tuser, m_tlast}, 2'b00);
    check("rst_pulses", {line_err, frame_done}, 2'b00);
    check("rst_s_tready", s_tready, 1'b1);
    capture_rst_n = 1'b1;
    @(posedge pclk);
    #1;

    // Table: one uniform-pattern frame per vector, later ones under random backpressure.
    for (int i = 0; i < 6; i++) begin
      rdy_mode = (i >= 3) ? 2 : 0;
      use_vec(i);
      snap();
      send_frame();
      drain();
      check_counts(tbl[i].name, 8, 0, 1);
    end
    rdy_mode = 0;
    repeat (2) @(posedge pclk);
    #1;

    // Output stall: first output held 5 cycles, input blocked, nothing lost.
    use_vec(1);
    snap();
    rdy_mode = 1;
    @(posedge pclk);
    #2;
    send_line(0, 0, W - 1, 1'b1, 1'b1);
    send_line(1, 0, 1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge pclk);
      check("stall_hold", {s_tready, m_tvalid, m_tuser, m_tlast, m_tdata}, {4'b0110, 16'h1DE0});
    end
    rdy_mode = 0;
    send_line(1, 2, W - 1, 1'b0, 1'b1);
    send_line(2, 0, W - 1, 1'b0, 1'b1);
    send_line(3, 0, W - 1, 1'b0, 1'b1);
    drain();
    check_counts("stall", 8, 0, 1);

    // Short odd row ending on an even column: half-pair dropped, no m_tlast.
    use_vec(1);
    snap();
    send_line(0, 0, W - 1, 1'b1, 1'b1);
    send_line(1, 0, 4, 1'b0, 1'b1);
    send_line(2, 0, W - 1, 1'b0, 1'b1);
    send_line(3, 0, W - 1, 1'b0, 1'b1);
    drain();
    check_counts("short_line", 6, 1, 1);

    // Mid-frame restart on row 2: new frame begins with m_tuser.
    use_vec(0);
    snap();
    send_line(0, 0, W - 1, 1'b1, 1'b1);
    send_line(1, 0, W - 1, 1'b0, 1'b1);
    send_line(2, 0, 2, 1'b0, 1'b0);
    use_vec(4);
    send_frame();
    drain();
    check_counts("restart", 12, 0, 1);

    // Async reset with a held output, then headless rows, then a real frame.
    use_vec(5);
    rdy_mode = 1;
    @(posedge pclk);
    #2;
    send_line(0, 0, W - 1, 1'b1, 1'b1);
    send_line(1, 0, 1, 1'b0, 1'b0);
    @(negedge pclk);
    check("pre_reset_valid", m_tvalid, 1'b1);
    #2;
    capture_rst_n = 1'b0;
    #1;
    check("async_reset_out", {m_tvalid, m_tuser, m_tlast, m_tdata}, 19'd0);
    q.delete();
    exp_sof = 1'b0;
    @(posedge pclk);
    @(posedge pclk);
    #1;
    capture_rst_n = 1'b1;
    rdy_mode = 0;
    @(posedge pclk);
    #2;
    snap();
    use_vec(2);
    send_line(0, 0, W - 1, 1'b0, 1'b1);
    send_line(1, 0, W - 1, 1'b0, 1'b1);
    use_vec(1);
    send_frame();
    drain();
    check_counts("after_reset", 12, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
